// File: rtl/fpga_spi_pkg.sv
// fpga_spi_pkg
// Shared definitions for the FPGA configuration SPI responder:
//   - spi_state_e : frame decoder states
//   - CMD_BITS    : width of the command/address word (also the data word width)
//   - FRAME_BITS  : total bits in one frame (command word + data word)
//   - RW_BIT      : frame bit index of the read/write flag (1 = write)
package fpga_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        RDATA,
        DONE
    } spi_state_e;

    localparam int CMD_BITS   = 16;
    localparam int FRAME_BITS = 2 * CMD_BITS;
    localparam int RW_BIT     = FRAME_BITS - 1;

endpackage

// File: rtl/fpga_spi_slave_if.sv
// fpga_spi_slave_if
// Register-bank bus between the SPI responder and the register file.
//   reg_addr  : captured register address (DATA_W-1 bits)
//   reg_wdata : captured write data
//   reg_wr    : one-cycle write strobe
//   reg_rd    : one-cycle read strobe
//   reg_rdata : read data, valid the cycle after reg_rd
// modport master : the SPI responder (issues strobes, receives read data)
// modport slave  : the register bank (receives strobes, returns read data)
interface fpga_spi_slave_if #(
    parameter int DATA_W = 16
) ();

    logic [DATA_W-2:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic              reg_wr;
    logic              reg_rd;
    logic [DATA_W-1:0] reg_rdata;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_wr,
        output reg_rd,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_wr,
        input  reg_rd,
        output reg_rdata
    );

endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
// Brings the asynchronous SPI pins into the clk domain and produces
// registered level/edge information for the frame decoder.
//   clk, reset_n          : system clock, async active-low reset
//   sclk_i, mosi_i, ss_n_i: raw pad inputs
//   sclk_rise_o/fall_o    : one-cycle pulses on synchronized SCLK edges
//   mosi_o                : synchronized MOSI, aligned with the SCLK pulses
//   ss_n_o                : synchronized slave select level
//   ss_fall_o/ss_rise_o   : one-cycle pulses on synchronized ss_n edges
//   flushed_o             : high once the pipeline holds real pad samples
// Every pulse and level appears SYNC_STAGES+1 clk after the pad change.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sclk_i,
    input  logic mosi_i,
    input  logic ss_n_i,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic mosi_o,
    output logic ss_n_o,
    output logic ss_fall_o,
    output logic ss_rise_o,
    output logic flushed_o
);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
    logic sclk_lvl_q, sclk_lvl_d;
    logic mosi_lvl_q, mosi_lvl_d;
    logic ss_lvl_q,   ss_lvl_d;
    logic sclk_rise_q, sclk_rise_d;
    logic sclk_fall_q, sclk_fall_d;
    logic ss_fall_q,   ss_fall_d;
    logic ss_rise_q,   ss_rise_d;
    logic [SYNC_STAGES:0] flush_q, flush_d;

    // The level register doubles as the "previous value" for edge detection,
    // so each pulse coincides with the cycle its level register changes.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0],   ss_n_i};
        sclk_lvl_d  = sclk_sync_q[SYNC_STAGES-1];
        mosi_lvl_d  = mosi_sync_q[SYNC_STAGES-1];
        ss_lvl_d    = ss_sync_q[SYNC_STAGES-1];
        sclk_rise_d =  sclk_sync_q[SYNC_STAGES-1] & ~sclk_lvl_q;
        sclk_fall_d = ~sclk_sync_q[SYNC_STAGES-1] &  sclk_lvl_q;
        ss_rise_d   =  ss_sync_q[SYNC_STAGES-1]   & ~ss_lvl_q;
        ss_fall_d   = ~ss_sync_q[SYNC_STAGES-1]   &  ss_lvl_q;
        // A 1 walks through one flop per pipeline stage after reset; when it
        // reaches the end, the reset values have been flushed out.
        flush_d     = {flush_q[SYNC_STAGES-1:0], 1'b1};
    end

    // ss_n resets high (deselected) so reset never looks like a frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sclk_lvl_q  <= 1'b0;
            mosi_lvl_q  <= 1'b0;
            ss_lvl_q    <= 1'b1;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            ss_fall_q   <= 1'b0;
            ss_rise_q   <= 1'b0;
            flush_q     <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ss_sync_q   <= ss_sync_d;
            sclk_lvl_q  <= sclk_lvl_d;
            mosi_lvl_q  <= mosi_lvl_d;
            ss_lvl_q    <= ss_lvl_d;
            sclk_rise_q <= sclk_rise_d;
            sclk_fall_q <= sclk_fall_d;
            ss_fall_q   <= ss_fall_d;
            ss_rise_q   <= ss_rise_d;
            flush_q     <= flush_d;
        end
    end

    assign sclk_rise_o = sclk_rise_q;
    assign sclk_fall_o = sclk_fall_q;
    assign mosi_o      = mosi_lvl_q;
    assign ss_n_o      = ss_lvl_q;
    assign ss_fall_o   = ss_fall_q;
    assign ss_rise_o   = ss_rise_q;
    assign flushed_o   = flush_q[SYNC_STAGES];

endmodule

// File: rtl/fpga_spi_slave.sv
// fpga_spi_slave
// SPI mode-0 responder for the FPGA configuration bus. Decodes 2*DATA_W-bit
// frames (R/W + address word, then data word) into single-cycle register
// write/read strobes and returns read data on MISO within the same frame.
//   clk, reset_n  : system clock, async active-low reset
//   spi_sclk      : SPI clock (asynchronous to clk)
//   spi_mosi      : serial data in, MSB first
//   spi_ss_n      : active-low slave select, frame boundary
//   spi_miso      : serial data out, MSB first
//   spi_miso_oe   : MISO pad output enable
//   frame_abort   : one-cycle pulse when a frame ends early
//   reg_bus       : register-bank bus (address, write data, strobes, read data)
module fpga_spi_slave
    import fpga_spi_pkg::*;
#(
    parameter int DATA_W      = CMD_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic spi_sclk,
    input  logic spi_mosi,
    input  logic spi_ss_n,
    output logic spi_miso,
    output logic spi_miso_oe,
    output logic frame_abort,
    fpga_spi_slave_if.master reg_bus
);

    localparam int FRAME_W = 2 * DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int RW_IDX  = DATA_W - 1;

    logic sclk_rise, sclk_fall, mosi_lvl, ss_lvl, ss_fall, ss_rise, flushed;

    spi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .sclk_i     (spi_sclk),
        .mosi_i     (spi_mosi),
        .ss_n_i     (spi_ss_n),
        .sclk_rise_o(sclk_rise),
        .sclk_fall_o(sclk_fall),
        .mosi_o     (mosi_lvl),
        .ss_n_o     (ss_lvl),
        .ss_fall_o  (ss_fall),
        .ss_rise_o  (ss_rise),
        .flushed_o  (flushed)
    );

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-2:0] rx_q, rx_d;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic              miso_q, miso_d;
    logic [DATA_W-2:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic              rd_dly_q, rd_dly_d;
    logic              abort_q, abort_d;
    logic              armed_q, armed_d;

    // Frame decoder. rx only keeps DATA_W-1 bits because the newest bit comes
    // straight from mosi_lvl, so rx_next is the complete word on the last
    // rising edge of each half-frame.
    // armed_q blocks a frame start until ss_n has genuinely been seen high
    // after reset, so a reset in the middle of a frame discards the remainder.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        miso_d   = miso_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_d     = 1'b0;
        rd_d     = 1'b0;
        rd_dly_d = rd_q;
        abort_d  = 1'b0;
        armed_d  = armed_q | (flushed & ss_lvl);
        rx_next  = {rx_q, mosi_lvl};

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (ss_fall && armed_q) begin
                    state_d = ADDR;
                end
            end

            ADDR: begin
                if (ss_rise) begin
                    abort_d = (cnt_q != '0);
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    rx_d  = rx_next[DATA_W-2:0];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        addr_d = rx_next[DATA_W-2:0];
                        if (rx_next[RW_IDX]) begin
                            state_d = WDATA;
                        end else begin
                            rd_d    = 1'b1;
                            state_d = RDATA;
                        end
                    end
                end
            end

            WDATA: begin
                if (ss_rise) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    rx_d  = rx_next[DATA_W-2:0];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                        wdata_d = rx_next;
                        wr_d    = 1'b1;
                        state_d = DONE;
                    end
                end
            end

            RDATA: begin
                if (ss_rise) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    // The bus timing guarantees the first falling edge arrives
                    // well after the read data has been loaded.
                    if (sclk_fall) begin
                        miso_d = tx_q[DATA_W-1];
                        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                    end
                    if (rd_dly_q) begin
                        tx_d = reg_bus.reg_rdata;
                    end
                    if (sclk_rise) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                            state_d = DONE;
                        end
                    end
                end
            end

            DONE: begin
                if (ss_rise) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // MISO is only ever driven with data while the read half is running.
        if (state_d != RDATA) begin
            miso_d = 1'b0;
        end
        if (state_d == IDLE) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rx_q     <= '0;
            tx_q     <= '0;
            miso_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            rd_dly_q <= 1'b0;
            abort_q  <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            miso_q   <= miso_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            rd_dly_q <= rd_dly_d;
            abort_q  <= abort_d;
            armed_q  <= armed_d;
        end
    end

    assign spi_miso          = miso_q;
    assign spi_miso_oe       = ~ss_lvl;
    assign frame_abort       = abort_q;
    assign reg_bus.reg_addr  = addr_q;
    assign reg_bus.reg_wdata = wdata_q;
    assign reg_bus.reg_wr    = wr_q;
    assign reg_bus.reg_rd    = rd_q;

endmodule

// File: tb/tb_fpga_spi_slave.sv
// tb_fpga_spi_slave
// Drives SPI frames into fpga_spi_slave as a mode-0 master, predicts the
// register strobes from the frame contents and compares them as the DUT
// emits them; MISO is captured on SCLK rising edges like a real master.
module tb_fpga_spi_slave;
    import fpga_spi_pkg::*;

    localparam int EV_WR    = 1;
    localparam int EV_RD    = 2;
    localparam int EV_ABORT = 3;

    typedef struct {
        int          kind;
        logic [14:0] addr;
        logic [15:0] data;
    } ev_t;

    logic clk;
    logic reset_n;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_ss_n;
    logic spi_miso;
    logic spi_miso_oe;
    logic frame_abort;
    logic [15:0] rd_value;

    ev_t sb[$];
    int  n_checks;
    int  n_pass;

    fpga_spi_slave_if #(.DATA_W(16)) reg_bus ();

    fpga_spi_slave #(
        .DATA_W     (16),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_ss_n   (spi_ss_n),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .frame_abort(frame_abort),
        .reg_bus    (reg_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Register bank: read data is valid only for the single cycle after
    // reg_rd, and deliberately wrong at every other time.
    always begin
        @(negedge clk);
        if (reset_n && reg_bus.reg_rd) begin
            @(posedge clk);
            #1 reg_bus.reg_rdata = rd_value;
            @(posedge clk);
            #1 reg_bus.reg_rdata = ~rd_value;
        end else begin
            reg_bus.reg_rdata = ~rd_value;
        end
    end

    task automatic check_event(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            check_output("unexpected_strobe", 32'(kind), 32'd0);
        end else begin
            e = sb.pop_front();
            check_output("strobe_kind", 32'(kind), 32'(e.kind));
            if (kind == e.kind && kind != EV_ABORT) begin
                check_output("reg_addr", 32'(reg_bus.reg_addr), 32'(e.addr));
            end
            if (kind == e.kind && kind == EV_WR) begin
                check_output("reg_wdata", 32'(reg_bus.reg_wdata), 32'(e.data));
            end
        end
    endtask

    // Monitor: every strobe the DUT presents must match the next prediction.
    always @(negedge clk) begin
        if (reset_n) begin
            if (reg_bus.reg_wr) check_event(EV_WR);
            if (reg_bus.reg_rd) check_event(EV_RD);
            if (frame_abort)    check_event(EV_ABORT);
        end
    end

    // One SPI transaction. nbits clocks are sent (beyond 32 the extra MOSI
    // bits are random); reset_at > 0 pulses reset_n after that rising edge.
    task automatic apply_stimulus(input logic [31:0] word, input int nbits, input int half,
                                  input int reset_at, input logic [15:0] rdata_val);
        logic [31:0] cap;
        logic [31:0] exp_cap;
        logic [31:0] mask;
        int          eff;
        ev_t         e;
        rd_value = rdata_val;
        eff      = (reset_at > 0) ? reset_at : nbits;
        e.addr   = word[30:16];
        e.data   = word[15:0];
        if (eff >= 16 && !word[RW_BIT]) begin
            e.kind = EV_RD;
            sb.push_back(e);
        end
        if (eff >= FRAME_BITS && word[RW_BIT]) begin
            e.kind = EV_WR;
            sb.push_back(e);
        end
        if (reset_at == 0 && nbits > 0 && nbits < FRAME_BITS) begin
            e.kind = EV_ABORT;
            sb.push_back(e);
        end
        exp_cap = word[RW_BIT] ? 32'd0 : {16'd0, rdata_val};
        cap     = '0;

        spi_ss_n = 1'b0;
        wait_clk(half + 1);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 32) ? word[31 - i] : 1'($urandom);
            wait_clk(half);
            spi_sclk = 1'b1;
            if (i < 32) cap[31 - i] = spi_miso;
            if (i + 1 == reset_at) begin
                reset_n = 1'b0;
                #1;
                check_output("rst_miso_oe", 32'(spi_miso_oe), 32'd0);
                check_output("rst_miso", 32'(spi_miso), 32'd0);
                check_output("rst_reg_wr", 32'(reg_bus.reg_wr), 32'd0);
                check_output("rst_reg_rd", 32'(reg_bus.reg_rd), 32'd0);
                wait_clk(3);
                reset_n = 1'b1;
            end
            wait_clk(half);
            spi_sclk = 1'b0;
        end
        wait_clk(half + 1);
        spi_ss_n = 1'b1;
        if (reset_at == 0 && nbits > 0) begin
            mask = (nbits >= 32) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> nbits);
            check_output("miso_bits", cap & mask, exp_cap & mask);
        end
        wait_clk(12);
        check_output("sb_drain", 32'(sb.size()), 32'd0);
        if (sb.size() != 0) sb.delete();
    endtask

    initial begin
        logic [31:0] w;
        int          sel;
        int          nb;
        n_checks = 0;
        n_pass   = 0;
        rd_value = 16'h0;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        spi_ss_n = 1'b1;
        reset_n  = 1'b1;
        #1 reset_n = 1'b0;
        wait_clk(3);
        check_output("reset_miso", 32'(spi_miso), 32'd0);
        check_output("reset_miso_oe", 32'(spi_miso_oe), 32'd0);
        check_output("reset_reg_addr", 32'(reg_bus.reg_addr), 32'd0);
        check_output("reset_reg_wdata", 32'(reg_bus.reg_wdata), 32'd0);
        check_output("reset_reg_wr", 32'(reg_bus.reg_wr), 32'd0);
        check_output("reset_reg_rd", 32'(reg_bus.reg_rd), 32'd0);
        check_output("reset_abort", 32'(frame_abort), 32'd0);
        reset_n = 1'b1;
        wait_clk(10);

        $display("[TB] directed frames");
        apply_stimulus(32'h8003_ABCD, 32, 5, 0, 16'h0000);
        apply_stimulus(32'h0005_0000, 32, 5, 0, 16'h1234);
        apply_stimulus(32'h8009_1111, 20, 5, 0, 16'h0000);
        apply_stimulus(32'h8001_00FF, 32, 5, 0, 16'h0000);
        apply_stimulus(32'h8002_5555, 40, 5, 0, 16'h0000);
        apply_stimulus(32'h0007_0000, 32, 5, 24, 16'hFFFF);
        apply_stimulus(32'h0007_0000, 32, 5, 0, 16'hFFFF);

        $display("[TB] random frames");
        for (int k = 0; k < 24; k++) begin
            w   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)      nb = 0;
            else if (sel <= 2) nb = $urandom_range(1, 31);
            else if (sel == 3) nb = $urandom_range(33, 40);
            else               nb = 32;
            apply_stimulus(w, nb, $urandom_range(6, 8), 0, 16'($urandom));
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
